rr_stream_mux: RTL
==================

Name: rr_stream_mux

Overview:
- Parametrised N:1 multiplexer with valid/ready handshakes on every input channel and a single registered output.
- It arbitrates between the input channels, either round-robin or fixed-priority, and forwards one beat per cycle.
- It generalises the team's 3:1 combinational select mux into a flow-controlled, arbitrated datapath stage.
- It sits between multiple producer blocks and one shared consumer.

Parameters:
- WIDTH, 8, data width of each channel in bits (>=1).
- NUM_CH, 3, number of input channels (>=2).
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- Local CH_W = max(1, clog2(NUM_CH)), width of the channel index.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NUM_CH  bit i set = channel i presents a beat.
- in_data  input  NUM_CH*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_CH  bit i set = channel i beat accepted this cycle (combinational).
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  forwarded data.
- out_ch  output  CH_W  index of the channel that sourced out_data.
- out_ready  input  1  consumer accepts the beat this cycle.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_ch=0, internal last-grant pointer ptr=NUM_CH-1. While rst=1, in_ready=0 regardless of other inputs.
- load = !out_valid | out_ready. The output register may take a new beat only when load=1.
- Grant, MODE=0: search in_valid starting at index (ptr+1) mod NUM_CH and wrapping upward; the first set bit is the grant g. After reset channel 0 has top priority.
- Grant, MODE=1: g = lowest index with in_valid set; ptr is never updated.
- in_ready is one-hot or zero. in_ready[g] = load & any(in_valid) & !rst. All other bits are 0. in_ready never depends on in_valid of the same channel alone; it depends only on grant and load.
- Transfer on channel i occurs when in_valid[i] & in_ready[i] at a rising edge.
- On a transfer: out_data<=in_data[g], out_ch<=g, out_valid<=1. In MODE=0, ptr<=g.
- On load=1 with no in_valid bit set: out_valid<=0; out_data and out_ch hold their previous values; ptr holds.
- On load=0 (out_valid=1 and out_ready=0): out_valid, out_data, out_ch and ptr all hold. in_ready is all zero (backpressure).
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle when out_ready is held at 1.
- Fairness (MODE=0): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NUM_CH-1,0,... with no channel starved. A channel that drops valid is skipped without an idle cycle.
- Pointer wrap: when ptr=NUM_CH-1 the search starts at 0. Non-power-of-two NUM_CH never yields an index >= NUM_CH.
- Simultaneous out_ready=1 and a new grant in the same cycle: the old beat is consumed and the new beat is loaded in that edge. There is no bubble.
- Input rule: an input whose valid is asserted keeps its data stable until accepted. The block does not check this rule.
- Reset mid-operation: any held beat is discarded (out_valid=0 on the next cycle), ptr returns to NUM_CH-1, and no in_ready is asserted during reset.
- No combinational path from out_ready to out_data/out_valid. The path out_ready -> in_ready is combinational.

Test Plan:
- Reset (NUM_CH=3, WIDTH=8): assert rst for 2 cycles with all in_valid=1 -> in_ready=000 throughout; after release out_valid=0 and out_ch=0. First grant goes to ch0 (in_ready=001).
- Round-robin (MODE=0): hold in_valid=111 with data 0xA0/0xB1/0xC2 and out_ready=1 -> out_data sequence 0xA0,0xB1,0xC2,0xA0 and out_ch sequence 0,1,2,0, one per cycle.
- Skip and wrap (MODE=0): last grant ch2, then in_valid=010 -> ch1 granted next cycle. Then in_valid=101 after ch1 -> ch2, then ch0.
- Backpressure: out_valid=1 with 0x55, drop out_ready for 3 cycles with in_valid=111 -> in_ready=000, out_data holds 0x55 and ptr is unchanged. On out_ready=1, 0x55 is consumed and the next channel loads on the same edge.
- Fixed priority (MODE=1): in_valid=110 for 4 cycles with out_ready=1 -> ch1 granted every cycle and ch2 is starved. Set in_valid=111 -> ch0 is granted.
- Mid-operation reset: while out_valid=1 and out_ready=0, pulse rst for 1 cycle -> out_valid=0 next cycle. The next grant with in_valid=111 is ch0.

Source files
------------

// File: rtl/rr_stream_mux_if.sv
// Stream bundle for rr_stream_mux: NUM_CH producer channels in, one registered beat out.
// The master side is the surrounding logic; the slave side is the mux itself.
interface rr_stream_mux_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 3
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream mux with round-robin (MODE=0) or fixed-priority (MODE=1)
// arbitration and a single output register; one beat per cycle, no bubble on reload.
module rr_stream_mux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 3,
  parameter int MODE   = 0,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  rr_stream_mux_if.slave bus
);

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [CH_W-1:0]   ptr;

  logic              load;
  logic              any_valid;
  logic [CH_W-1:0]   g;
  logic [CH_W-1:0]   g_hi;
  logic [CH_W-1:0]   g_lo;
  logic              hi_found;
  logic [NUM_CH-1:0] ready;

  assign load      = !out_valid_q || bus.out_ready;
  assign any_valid = |bus.in_valid;

  // Round-robin = lowest valid index above ptr, else lowest valid index overall
  // (the wrap). Fixed priority never takes the "above ptr" branch.
  always_comb begin
    g_hi     = '0;
    g_lo     = '0;
    hi_found = 1'b0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        g_lo = CH_W'(i);
        if (MODE == 0 && i > int'(ptr)) begin
          g_hi     = CH_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    g = hi_found ? g_hi : g_lo;
  end

  always_comb begin
    ready = '0;
    if (load && any_valid && !rst) ready[g] = 1'b1;
  end

  assign bus.in_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr         <= CH_W'(NUM_CH-1);
    end else if (load) begin
      if (any_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data[int'(g)*WIDTH +: WIDTH];
        out_ch_q    <= g;
        if (MODE == 0) ptr <= g;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule
